uart_io_bridge: RTL

- Host-driven debug initiator for the on-chip I/O bus; the bus master's side of the peripheral register map.
- Receives framed command bytes from the buart receive interface.
- Issues single io_wr / io_rd cycles with the same address/data/strobe timing the CPU uses.
- Returns acknowledge or read-data bytes through the buart transmit interface.
- The top level muxes it onto the peripheral bus alongside the CPU and gives it priority while `active` is high.

---
 rtl/uart_io_bridge.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_io_bridge.sv
// ---------------------------------------------------------------------------
// uart_io_bridge
//
// Host-driven debug initiator for the on-chip I/O bus. Command frames arrive
// byte by byte from the buart receiver, are decoded into a single io_wr or
// io_rd cycle, and an acknowledge or the read data is returned through the
// buart transmitter. The top level gives this block bus priority while
// `active` is high.
//
// Frames (multi-byte fields big-endian):
//   'W' A1 A0 D3 D2 D1 D0  -> write, response 'K'
//   'R' A1 A0              -> read,  response D3 D2 D1 D0
//   anything else          -> response '?'
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   uart_valid    receive byte available
//   uart_rx_data  received byte
//   uart_rd       one-cycle pulse consuming the current receive byte
//   uart_busy     transmitter busy
//   uart_wr       one-cycle pulse launching uart_tx_data
//   uart_tx_data  byte to transmit, held until the next uart_wr
//   io_addr       bus address (holds after the transaction)
//   io_dout       bus write data (holds after the transaction)
//   io_wr         one-cycle write strobe
//   io_rd         one-cycle read strobe
//   io_din        bus read data, valid RD_LAT cycles after io_rd
//   active        bridge owns the bus / is mid-command
// ---------------------------------------------------------------------------
module uart_io_bridge #(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rd,
  input  logic        uart_busy,
  output logic        uart_wr,
  output logic [7:0]  uart_tx_data,
  output logic [15:0] io_addr,
  output logic [31:0] io_dout,
  output logic        io_wr,
  output logic        io_rd,
  input  logic [31:0] io_din,
  output logic        active
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR   = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] BUSWR  = 3'd3;
  localparam logic [2:0] BUSRD  = 3'd4;
  localparam logic [2:0] RDWAIT = 3'd5;
  localparam logic [2:0] RESP   = 3'd6;
  localparam logic [2:0] TXGAP  = 3'd7;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_BAD   = 8'h3F;  // '?'

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int LW = $clog2(RD_LAT + 1) + 1;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  logic [2:0]       state_reg, state_next;
  logic             is_write_reg, is_write_next;
  logic [1:0]       byte_cnt_reg, byte_cnt_next;
  logic [TW-1:0]    tmo_cnt_reg, tmo_cnt_next;
  logic [LW-1:0]    lat_cnt_reg, lat_cnt_next;
  logic [2:0]       resp_left_reg, resp_left_next;

  logic             uart_rd_reg, uart_rd_next;
  logic             uart_wr_reg, uart_wr_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic [15:0]      io_addr_reg, io_addr_next;
  logic [31:0]      io_dout_reg, io_dout_next;
  logic             io_wr_reg, io_wr_next;
  logic             io_rd_reg, io_rd_next;
  logic             active_reg, active_next;

  // Response queue: lane 0 is the next byte to go out. Lane 4 of the chain
  // is a constant zero fed into lane 3 as bytes shift out.
  logic [3:0][7:0]  resp_byte_reg;
  logic [3:0][7:0]  resp_byte_next;
  logic [4:0][7:0]  resp_chain;

  logic             load_din;
  logic             load_code;
  logic             shift_resp;
  logic [7:0]       code_byte;

  // A byte is taken only in the collecting states, and never on the cycle
  // right after a uart_rd pulse: the receiver still shows the consumed byte
  // as valid during that cycle.
  logic accept;
  assign accept = uart_valid && !uart_rd_reg &&
                  ((state_reg == IDLE) || (state_reg == ADDR) || (state_reg == DATA));

  // -------------------------------------------------------------------------
  // Response byte lanes
  // -------------------------------------------------------------------------
  assign resp_chain[4]   = 8'h00;
  assign resp_chain[3:0] = resp_byte_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_resp_lane
      // Read data is loaded big-endian so D3 leaves first.
      assign resp_byte_next[gi] =
        load_din   ? io_din[8*(3-gi) +: 8] :
        load_code  ? ((gi == 0) ? code_byte : 8'h00) :
        shift_resp ? resp_chain[gi+1] :
                     resp_byte_reg[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    is_write_next  = is_write_reg;
    byte_cnt_next  = byte_cnt_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    lat_cnt_next   = lat_cnt_reg;
    resp_left_next = resp_left_reg;
    uart_rd_next   = accept;
    uart_wr_next   = 1'b0;
    tx_data_next   = tx_data_reg;
    io_addr_next   = io_addr_reg;
    io_dout_next   = io_dout_reg;
    io_wr_next     = 1'b0;
    io_rd_next     = 1'b0;
    active_next    = active_reg;
    load_din       = 1'b0;
    load_code      = 1'b0;
    shift_resp     = 1'b0;
    code_byte      = 8'h00;

    case (state_reg)
      IDLE: begin
        tmo_cnt_next = '0;
        if (accept) begin
          active_next   = 1'b1;
          byte_cnt_next = 2'd0;
          if ((uart_rx_data == CMD_WRITE) || (uart_rx_data == CMD_READ)) begin
            is_write_next = (uart_rx_data == CMD_WRITE);
            state_next    = ADDR;
          end else begin
            load_code      = 1'b1;
            code_byte      = RSP_BAD;
            resp_left_next = 3'd1;
            state_next     = RESP;
          end
        end
      end

      ADDR: begin
        if (accept) begin
          tmo_cnt_next  = '0;
          io_addr_next  = {io_addr_reg[7:0], uart_rx_data};
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd1) begin
            byte_cnt_next = 2'd0;
            state_next    = is_write_reg ? DATA : BUSRD;
          end
        end else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
          // Host went silent mid-command: drop it without touching the bus.
          tmo_cnt_next = '0;
          active_next  = 1'b0;
          state_next   = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end

      DATA: begin
        if (accept) begin
          tmo_cnt_next  = '0;
          io_dout_next  = {io_dout_reg[23:0], uart_rx_data};
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            byte_cnt_next = 2'd0;
            state_next    = BUSWR;
          end
        end else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
          tmo_cnt_next = '0;
          active_next  = 1'b0;
          state_next   = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end

      BUSWR: begin
        // The strobe register goes high on leaving this state, so io_wr is
        // seen during the first RESP cycle with address/data untouched.
        io_wr_next     = 1'b1;
        load_code      = 1'b1;
        code_byte      = RSP_ACK;
        resp_left_next = 3'd1;
        state_next     = RESP;
      end

      BUSRD: begin
        io_rd_next   = 1'b1;
        lat_cnt_next = '0;
        state_next   = RDWAIT;
      end

      RDWAIT: begin
        // The first RDWAIT cycle is the io_rd cycle itself; io_din is
        // sampled RD_LAT cycles after it.
        if (lat_cnt_reg == LW'(RD_LAT)) begin
          load_din       = 1'b1;
          resp_left_next = 3'd4;
          state_next     = RESP;
        end else begin
          lat_cnt_next = lat_cnt_reg + LW'(1);
        end
      end

      RESP: begin
        if (!uart_busy) begin
          uart_wr_next   = 1'b1;
          tx_data_next   = resp_byte_reg[0];
          shift_resp     = 1'b1;
          resp_left_next = resp_left_reg - 3'd1;
          state_next     = TXGAP;
        end
      end

      TXGAP: begin
        // uart_busy only rises the cycle after uart_wr, so it is not
        // trusted here.
        if (resp_left_reg != 3'd0) begin
          state_next = RESP;
        end else begin
          active_next = 1'b0;
          state_next  = IDLE;
        end
      end

      default: begin
        state_next  = IDLE;
        active_next = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      is_write_reg  <= 1'b0;
      byte_cnt_reg  <= 2'd0;
      tmo_cnt_reg   <= '0;
      lat_cnt_reg   <= '0;
      resp_left_reg <= 3'd0;
      resp_byte_reg <= '0;
      uart_rd_reg   <= 1'b0;
      uart_wr_reg   <= 1'b0;
      tx_data_reg   <= 8'h00;
      io_addr_reg   <= 16'h0000;
      io_dout_reg   <= 32'h0000_0000;
      io_wr_reg     <= 1'b0;
      io_rd_reg     <= 1'b0;
      active_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      is_write_reg  <= is_write_next;
      byte_cnt_reg  <= byte_cnt_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      lat_cnt_reg   <= lat_cnt_next;
      resp_left_reg <= resp_left_next;
      resp_byte_reg <= resp_byte_next;
      uart_rd_reg   <= uart_rd_next;
      uart_wr_reg   <= uart_wr_next;
      tx_data_reg   <= tx_data_next;
      io_addr_reg   <= io_addr_next;
      io_dout_reg   <= io_dout_next;
      io_wr_reg     <= io_wr_next;
      io_rd_reg     <= io_rd_next;
      active_reg    <= active_next;
    end
  end

  assign uart_rd      = uart_rd_reg;
  assign uart_wr      = uart_wr_reg;
  assign uart_tx_data = tx_data_reg;
  assign io_addr      = io_addr_reg;
  assign io_dout      = io_dout_reg;
  assign io_wr        = io_wr_reg;
  assign io_rd        = io_rd_reg;
  assign active       = active_reg;

endmodule
